// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and frame constants shared by the SPI master files
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, HOLD, RELEASE} spi_state_t;
    localparam int CLK_DIV_MIN = 4;
    localparam int SPI_WIDTH = 8;
endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: reloadable down-counter, one-cycle tick every CLK_DIV enabled cycles
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tick
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);
    logic [W-1:0] r_cnt;
    assign o_tick = i_en && r_cnt == '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= TOP;
        else if (i_en) r_cnt <= o_tick ? TOP : r_cnt - 1'b1;
endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master, MSB first, 8-bit frames, ss optionally held low across bytes
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SPI_WIDTH-1:0] din,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic [SPI_WIDTH-1:0] dout,
    output logic                 ss,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso
);
    if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_div
        $error("spi_master: CLK_DIV must be at least %0d", CLK_DIV_MIN);
    end
    spi_state_t           r_state;
    logic [SPI_WIDTH-1:0] r_tx, r_rx, r_dout;
    logic [2:0]           r_bit;
    logic                 r_miso_m, r_miso_s;
    logic                 r_busy, r_done, r_ss, r_sck, r_mosi;
    logic                 w_tick, w_load;
    // the timer reloads whenever idle, so each busy phase starts a fresh half-period
    assign w_load = !r_busy;
    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk(clk),
        .rst(rst),
        .i_load(w_load),
        .i_en(r_busy),
        .o_tick(w_tick)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) {r_miso_m, r_miso_s} <= 2'b00;
        else {r_miso_m, r_miso_s} <= {miso, r_miso_m};
    // SETUP is entered with busy low; that first cycle drops ss and drives the MSB
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ss    <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, HOLD:
                    if (start) begin
                        r_tx    <= din;
                        r_state <= SETUP;
                    end else if (r_state == HOLD && !hold) begin
                        r_state <= RELEASE;
                        r_ss    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                SETUP:
                    if (!r_busy) begin
                        r_busy <= 1'b1;
                        r_ss   <= 1'b0;
                        r_mosi <= r_tx[SPI_WIDTH-1];
                    end else if (w_tick) begin
                        r_sck   <= 1'b1;
                        r_state <= SHIFT;
                    end
                SHIFT:
                    if (w_tick) begin
                        r_sck <= !r_sck;
                        if (r_sck) begin
                            r_rx  <= {r_rx[SPI_WIDTH-2:0], r_miso_s};
                            r_bit <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_done  <= 1'b1;
                                r_dout  <= {r_rx[SPI_WIDTH-2:0], r_miso_s};
                                r_state <= TAIL;
                            end else begin
                                r_mosi <= r_tx[SPI_WIDTH-2];
                                r_tx   <= {r_tx[SPI_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                TAIL:
                    if (w_tick) begin
                        r_state <= hold ? HOLD : RELEASE;
                        r_busy  <= !hold;
                        r_ss    <= !hold;
                    end
                RELEASE:
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                default: r_state <= IDLE;
            endcase
        end
    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;
    assign ss   = r_ss;
    assign sck  = r_sck;
    assign mosi = r_mosi;
endmodule
